alu_rr_arbiter: RTL and testbench

Round-robin arbiter sharing the single 4-operation ALU (sel 00 subtract, 01 nand, 10 starting-ones, 11 one-hot-to-U2) between two requesters. Accepts one operation at a time over valid/ready, issues it to the ALU, waits for the result under a watchdog, then returns the result with requester ID and sign flags. Sits between the two operation sources and the ALU's operand/result ports.

---
 rtl/alu_rr_arbiter_if.sv | 71 +++++++
 rtl/alu_rr_arbiter.sv | 171 +++++++++++++++++
 tb/tb_alu_rr_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rr_arbiter_if.sv
// Bundle of all handshake and data signals between the ALU arbiter and its
// environment: two operation requesters, the shared ALU and the response consumer.
// Signal names carry the arbiter's point of view (i_ = into arbiter, o_ = out of it).
interface alu_rr_arbiter_if #(
    parameter int WIDTH = 4
);
    // Requester 0
    logic             i_req0_VALID;
    logic             o_req0_READY;
    logic [1:0]       i_req0_sel;
    logic [WIDTH-1:0] i_req0_A;
    logic [WIDTH-1:0] i_req0_B;
    // Requester 1
    logic             i_req1_VALID;
    logic             o_req1_READY;
    logic [1:0]       i_req1_sel;
    logic [WIDTH-1:0] i_req1_A;
    logic [WIDTH-1:0] i_req1_B;
    // ALU operation channel
    logic             o_alu_VALID;
    logic             i_alu_READY;
    logic [1:0]       o_alu_sel;
    logic [WIDTH-1:0] o_alu_A;
    logic [WIDTH-1:0] o_alu_B;
    // ALU result channel
    logic             i_alu_VALID;
    logic             o_alu_READY;
    logic [WIDTH-1:0] i_alu_Y;
    logic             i_alu_err;
    logic             i_alu_overflow;
    // Response channel
    logic             o_rsp_VALID;
    logic             i_rsp_READY;
    logic             o_rsp_id;
    logic [WIDTH-1:0] o_rsp_Y;
    logic             o_rsp_err;
    logic             o_rsp_overflow;
    logic             o_rsp_neg;
    logic             o_rsp_pos;
    logic             o_rsp_timeout;

    // Arbiter side
    modport slave (
        input  i_req0_VALID, i_req0_sel, i_req0_A, i_req0_B,
        output o_req0_READY,
        input  i_req1_VALID, i_req1_sel, i_req1_A, i_req1_B,
        output o_req1_READY,
        output o_alu_VALID, o_alu_sel, o_alu_A, o_alu_B,
        input  i_alu_READY,
        input  i_alu_VALID, i_alu_Y, i_alu_err, i_alu_overflow,
        output o_alu_READY,
        output o_rsp_VALID, o_rsp_id, o_rsp_Y, o_rsp_err, o_rsp_overflow,
        output o_rsp_neg, o_rsp_pos, o_rsp_timeout,
        input  i_rsp_READY
    );

    // Environment side (requesters, ALU, consumer)
    modport master (
        output i_req0_VALID, i_req0_sel, i_req0_A, i_req0_B,
        input  o_req0_READY,
        output i_req1_VALID, i_req1_sel, i_req1_A, i_req1_B,
        input  o_req1_READY,
        input  o_alu_VALID, o_alu_sel, o_alu_A, o_alu_B,
        output i_alu_READY,
        output i_alu_VALID, i_alu_Y, i_alu_err, i_alu_overflow,
        input  o_alu_READY,
        input  o_rsp_VALID, o_rsp_id, o_rsp_Y, o_rsp_err, o_rsp_overflow,
        input  o_rsp_neg, o_rsp_pos, o_rsp_timeout,
        output i_rsp_READY
    );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter in front of a single shared ALU. One operation is in flight
// at a time: accept from a requester, issue to the ALU, wait for the result under a
// watchdog, then hand the result back tagged with requester id and sign flags.
// All outputs are registered except the requester READYs.
module alu_rr_arbiter #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             i_CLK,
    input  logic             i_RSTn,
    alu_rr_arbiter_if.slave  bus
);
    // Watchdog must be able to hold TIMEOUT-1
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [WDW-1:0]   wdog_q, wdog_d;
    logic             id_q, id_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             alu_valid_q, alu_valid_d;
    logic             alu_ready_q, alu_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             err_q, err_d;
    logic             ovf_q, ovf_d;
    logic             neg_q, neg_d;
    logic             pos_q, pos_d;
    logic             tmo_q, tmo_d;
    logic             grant0, grant1;

    // Grant: a lone requester always wins; on contention the pointer decides
    always_comb begin
        grant0 = bus.i_req0_VALID & (~bus.i_req1_VALID | ~ptr_q);
        grant1 = bus.i_req1_VALID & (~bus.i_req0_VALID |  ptr_q);
    end

    // READY is combinational so a requester sees acceptance in the same cycle;
    // qualified with reset so it is low while reset is held
    assign bus.o_req0_READY = i_RSTn & (state_q == S_IDLE) & grant0;
    assign bus.o_req1_READY = i_RSTn & (state_q == S_IDLE) & grant1;

    // Next-state and next-output computation for the whole transaction FSM
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wdog_d  = wdog_q;
        id_d    = id_q;
        sel_d   = sel_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        neg_d   = neg_q;
        pos_d   = pos_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (grant0 | grant1) begin
                    id_d    = grant1;
                    sel_d   = grant1 ? bus.i_req1_sel : bus.i_req0_sel;
                    a_d     = grant1 ? bus.i_req1_A   : bus.i_req0_A;
                    b_d     = grant1 ? bus.i_req1_B   : bus.i_req0_B;
                    ptr_d   = ~grant1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.i_alu_READY) begin
                    wdog_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A result on the last watchdog cycle still beats the timeout
                if (bus.i_alu_VALID) begin
                    y_d     = bus.i_alu_Y;
                    err_d   = bus.i_alu_err;
                    ovf_d   = bus.i_alu_overflow;
                    neg_d   = bus.i_alu_Y[WIDTH-1];
                    pos_d   = ~bus.i_alu_Y[WIDTH-1] & (|bus.i_alu_Y);
                    tmo_d   = 1'b0;
                    state_d = S_RESP;
                end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                    y_d     = '0;
                    err_d   = 1'b1;
                    ovf_d   = 1'b0;
                    neg_d   = 1'b0;
                    pos_d   = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    wdog_d  = wdog_q + WDW'(1);
                end
            end
            S_RESP: begin
                if (bus.i_rsp_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Handshake strobes are decoded from the next state so they are registered
        alu_valid_d = (state_d == S_ISSUE);
        alu_ready_d = (state_d == S_WAIT);
        rsp_valid_d = (state_d == S_RESP);
    end

    // State and registered outputs; reset discards any operation in flight
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q     <= S_IDLE;
            ptr_q       <= 1'b0;
            wdog_q      <= '0;
            id_q        <= 1'b0;
            sel_q       <= 2'b00;
            a_q         <= '0;
            b_q         <= '0;
            alu_valid_q <= 1'b0;
            alu_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            y_q         <= '0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            neg_q       <= 1'b0;
            pos_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            wdog_q      <= wdog_d;
            id_q        <= id_d;
            sel_q       <= sel_d;
            a_q         <= a_d;
            b_q         <= b_d;
            alu_valid_q <= alu_valid_d;
            alu_ready_q <= alu_ready_d;
            rsp_valid_q <= rsp_valid_d;
            y_q         <= y_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            neg_q       <= neg_d;
            pos_q       <= pos_d;
            tmo_q       <= tmo_d;
        end
    end

    assign bus.o_alu_VALID    = alu_valid_q;
    assign bus.o_alu_sel      = sel_q;
    assign bus.o_alu_A        = a_q;
    assign bus.o_alu_B        = b_q;
    assign bus.o_alu_READY    = alu_ready_q;
    assign bus.o_rsp_VALID    = rsp_valid_q;
    assign bus.o_rsp_id       = id_q;
    assign bus.o_rsp_Y        = y_q;
    assign bus.o_rsp_err      = err_q;
    assign bus.o_rsp_overflow = ovf_q;
    assign bus.o_rsp_neg      = neg_q;
    assign bus.o_rsp_pos      = pos_q;
    assign bus.o_rsp_timeout  = tmo_q;
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: the bench plays both requesters, the ALU and
// the response consumer, stepping cycle by cycle and comparing against hand values.
module tb_alu_rr_arbiter;
    logic i_CLK;
    logic i_RSTn;
    int   asserts = 0;
    int   fails   = 0;

    alu_rr_arbiter_if #(.WIDTH(4)) bus();

    alu_rr_arbiter #(.WIDTH(4), .TIMEOUT(15)) dut (
        .i_CLK  (i_CLK),
        .i_RSTn (i_RSTn),
        .bus    (bus)
    );

    initial i_CLK = 1'b0;
    always #5 i_CLK = ~i_CLK;

    // Response fields packed as {valid, id, Y, err, overflow, neg, pos, timeout}
    function automatic logic [10:0] rsp_vec();
        return {bus.o_rsp_VALID, bus.o_rsp_id, bus.o_rsp_Y, bus.o_rsp_err,
                bus.o_rsp_overflow, bus.o_rsp_neg, bus.o_rsp_pos, bus.o_rsp_timeout};
    endfunction

    // ALU-side fields packed as {alu_valid, alu_ready, sel, A, B}
    function automatic logic [11:0] alu_vec();
        return {bus.o_alu_VALID, bus.o_alu_READY, bus.o_alu_sel, bus.o_alu_A, bus.o_alu_B};
    endfunction

    task automatic tick();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_req0_VALID = 0; bus.i_req0_sel = 0; bus.i_req0_A = 0; bus.i_req0_B = 0;
        bus.i_req1_VALID = 0; bus.i_req1_sel = 0; bus.i_req1_A = 0; bus.i_req1_B = 0;
        bus.i_alu_READY = 0; bus.i_alu_VALID = 0; bus.i_alu_Y = 0;
        bus.i_alu_err = 0; bus.i_alu_overflow = 0; bus.i_rsp_READY = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        i_RSTn = 1'b0;
        tick();
        tick();
        i_RSTn = 1'b1;
        #1;
    endtask

    // Drive one operation from IDLE with everything ready; returns in the RESP cycle
    task automatic issue_min(input bit port, input logic [1:0] sel, input logic [3:0] a,
                             input logic [3:0] b, input logic [3:0] y,
                             input bit err, input bit ovf);
        bus.i_alu_READY = 1; bus.i_alu_VALID = 1; bus.i_rsp_READY = 1;
        bus.i_alu_Y = y; bus.i_alu_err = err; bus.i_alu_overflow = ovf;
        if (port) begin
            bus.i_req1_VALID = 1; bus.i_req1_sel = sel; bus.i_req1_A = a; bus.i_req1_B = b;
        end else begin
            bus.i_req0_VALID = 1; bus.i_req0_sel = sel; bus.i_req0_A = a; bus.i_req0_B = b;
        end
        tick();
        bus.i_req0_VALID = 0;
        bus.i_req1_VALID = 0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        i_RSTn = 1'b0;
        bus.i_req0_VALID = 1;
        #1;
        asserts++;
        if ({bus.o_req1_READY, bus.o_req0_READY, alu_vec(), rsp_vec()} !== 25'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {bus.o_req1_READY, bus.o_req0_READY, alu_vec(), rsp_vec()});
        end
        tick();
        i_RSTn = 1'b1;
        bus.i_req0_sel = 2'b01; bus.i_req0_A = 4'h3; bus.i_req0_B = 4'h5;
        bus.i_alu_READY = 1;
        #1;
        tick();                 // ISSUE
        bus.i_req0_VALID = 0;
        tick();                 // WAIT
        asserts++;
        if (alu_vec() !== {1'b0, 1'b1, 2'b01, 4'h3, 4'h5}) begin
            fails++;
            $display("FAIL reset_pre_wait: got %h expected %h", alu_vec(),
                     {1'b0, 1'b1, 2'b01, 4'h3, 4'h5});
        end
        #2;
        i_RSTn = 1'b0;
        bus.i_req0_VALID = 1;
        bus.i_alu_VALID = 1; bus.i_alu_Y = 4'h9;
        #1;
        asserts++;
        if ({bus.o_req1_READY, bus.o_req0_READY, alu_vec(), rsp_vec()} !== 25'd0) begin
            fails++;
            $display("FAIL reset_mid_wait: got %b expected all zero",
                     {bus.o_req1_READY, bus.o_req0_READY, alu_vec(), rsp_vec()});
        end
        tick();
        tick();
        i_RSTn = 1'b1;
        bus.i_alu_VALID = 0;
        #1;
        asserts++;
        if ({bus.o_req0_READY, bus.o_rsp_VALID} !== 2'b10) begin
            fails++;
            $display("FAIL reset_release_ready: got %b expected 10",
                     {bus.o_req0_READY, bus.o_rsp_VALID});
        end
        $display("reset: mid-WAIT reset discarded, req0 accepted after release");
    endtask

    task automatic test_single_op();
        do_reset();
        bus.i_req0_VALID = 1; bus.i_req0_sel = 2'b00; bus.i_req0_A = 4'h3; bus.i_req0_B = 4'h5;
        bus.i_alu_READY = 1; bus.i_alu_VALID = 1; bus.i_alu_Y = 4'hE; bus.i_rsp_READY = 1;
        #1;
        asserts++;
        if ({bus.o_req1_READY, bus.o_req0_READY} !== 2'b01) begin
            fails++;
            $display("FAIL single_accept: got %b expected 01", {bus.o_req1_READY, bus.o_req0_READY});
        end
        tick();                 // c1 ISSUE
        bus.i_req0_VALID = 0;
        asserts++;
        if ({alu_vec(), bus.o_rsp_VALID} !== {1'b1, 1'b0, 2'b00, 4'h3, 4'h5, 1'b0}) begin
            fails++;
            $display("FAIL single_issue: got %h expected %h", {alu_vec(), bus.o_rsp_VALID},
                     {1'b1, 1'b0, 2'b00, 4'h3, 4'h5, 1'b0});
        end
        tick();                 // c2 WAIT
        asserts++;
        if ({bus.o_alu_VALID, bus.o_alu_READY, bus.o_rsp_VALID} !== 3'b010) begin
            fails++;
            $display("FAIL single_wait: got %b expected 010",
                     {bus.o_alu_VALID, bus.o_alu_READY, bus.o_rsp_VALID});
        end
        tick();                 // c3 RESP
        asserts++;
        if (rsp_vec() !== {1'b1, 1'b0, 4'hE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL single_resp: got %b expected %b", rsp_vec(),
                     {1'b1, 1'b0, 4'hE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        end
        $display("single: id=%0d Y=%h neg=%0d pos=%0d", bus.o_rsp_id, bus.o_rsp_Y,
                 bus.o_rsp_neg, bus.o_rsp_pos);
        tick();                 // c4 IDLE
        bus.i_req0_VALID = 1;
        #1;
        asserts++;
        if ({bus.o_rsp_VALID, bus.o_req0_READY} !== 2'b01) begin
            fails++;
            $display("FAIL single_c4_accept: got %b expected 01", {bus.o_rsp_VALID, bus.o_req0_READY});
        end
        bus.i_req0_VALID = 0;
    endtask

    task automatic test_contention();
        do_reset();
        bus.i_req0_VALID = 1; bus.i_req0_sel = 2'b01; bus.i_req0_A = 4'h1; bus.i_req0_B = 4'h2;
        bus.i_req1_VALID = 1; bus.i_req1_sel = 2'b10; bus.i_req1_A = 4'h4; bus.i_req1_B = 4'h8;
        bus.i_alu_READY = 1; bus.i_alu_VALID = 1; bus.i_alu_Y = 4'h6; bus.i_rsp_READY = 1;
        #1;
        for (int k = 0; k < 4; k++) begin
            asserts++;
            if ({bus.o_req1_READY, bus.o_req0_READY} !== ((k % 2) ? 2'b10 : 2'b01)) begin
                fails++;
                $display("FAIL contention_grant%0d: got %b expected %b", k,
                         {bus.o_req1_READY, bus.o_req0_READY}, ((k % 2) ? 2'b10 : 2'b01));
            end
            tick(); tick(); tick();
            asserts++;
            if ({bus.o_rsp_VALID, bus.o_rsp_id} !== {1'b1, 1'(k % 2)}) begin
                fails++;
                $display("FAIL contention_id%0d: got %b expected %b", k,
                         {bus.o_rsp_VALID, bus.o_rsp_id}, {1'b1, 1'(k % 2)});
            end
            $display("contention: op %0d served id=%0d", k, bus.o_rsp_id);
            tick();
        end
        bus.i_req0_VALID = 0;
        #1;
        for (int k = 0; k < 4; k++) begin
            asserts++;
            if ({bus.o_req1_READY, bus.o_req0_READY} !== 2'b10) begin
                fails++;
                $display("FAIL lone_grant%0d: got %b expected 10", k,
                         {bus.o_req1_READY, bus.o_req0_READY});
            end
            tick(); tick(); tick();
            asserts++;
            if ({bus.o_rsp_VALID, bus.o_rsp_id} !== 2'b11) begin
                fails++;
                $display("FAIL lone_id%0d: got %b expected 11", k, {bus.o_rsp_VALID, bus.o_rsp_id});
            end
            $display("lone: op %0d served id=%0d", k, bus.o_rsp_id);
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back_backpressure();
        do_reset();
        bus.i_req1_VALID = 1; bus.i_req1_sel = 2'b10; bus.i_req1_A = 4'h9; bus.i_req1_B = 4'h6;
        bus.i_alu_Y = 4'h5;
        #1;
        asserts++;
        if ({bus.o_req1_READY, bus.o_req0_READY} !== 2'b10) begin
            fails++;
            $display("FAIL bp_accept: got %b expected 10", {bus.o_req1_READY, bus.o_req0_READY});
        end
        tick();                 // c1
        bus.i_req1_VALID = 0; bus.i_req1_A = 4'h0; bus.i_req1_sel = 2'b00;
        for (int i = 0; i < 4; i++) begin   // c1..c4, ALU ready only on c4
            if (i == 3) bus.i_alu_READY = 1;
            asserts++;
            if (alu_vec() !== {1'b1, 1'b0, 2'b10, 4'h9, 4'h6}) begin
                fails++;
                $display("FAIL bp_issue_hold%0d: got %h expected %h", i, alu_vec(),
                         {1'b1, 1'b0, 2'b10, 4'h9, 4'h6});
            end
            tick();
        end
        bus.i_alu_VALID = 1;                 // c5 WAIT
        asserts++;
        if ({bus.o_alu_VALID, bus.o_alu_READY} !== 2'b01) begin
            fails++;
            $display("FAIL bp_wait: got %b expected 01", {bus.o_alu_VALID, bus.o_alu_READY});
        end
        tick();
        bus.i_alu_VALID = 0; bus.i_alu_Y = 4'hF;
        for (int i = 0; i < 3; i++) begin   // c6..c8, consumer ready only on c8
            if (i == 2) bus.i_rsp_READY = 1;
            asserts++;
            if (rsp_vec() !== {1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
                fails++;
                $display("FAIL bp_resp_hold%0d: got %b expected %b", i, rsp_vec(),
                         {1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
            end
            tick();
        end
        $display("backpressure: id=1 Y=5 held through stalls");
        bus.i_req0_VALID = 1;                // c9 next accept
        #1;
        asserts++;
        if ({bus.o_rsp_VALID, bus.o_req0_READY} !== 2'b01) begin
            fails++;
            $display("FAIL bp_c9_accept: got %b expected 01", {bus.o_rsp_VALID, bus.o_req0_READY});
        end
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        bus.i_req0_VALID = 1; bus.i_req0_sel = 2'b11; bus.i_req0_A = 4'h1; bus.i_req0_B = 4'h2;
        bus.i_alu_READY = 1; bus.i_alu_Y = 4'hF; bus.i_rsp_READY = 1;
        tick();                 // c1 ISSUE
        bus.i_req0_VALID = 0;
        tick();                 // c2 WAIT entry
        for (int i = 0; i < 15; i++) begin
            asserts++;
            if ({bus.o_alu_READY, bus.o_rsp_VALID} !== 2'b10) begin
                fails++;
                $display("FAIL timeout_wait%0d: got %b expected 10", i,
                         {bus.o_alu_READY, bus.o_rsp_VALID});
            end
            tick();
        end
        asserts++;
        if (rsp_vec() !== {1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL timeout_resp: got %b expected %b", rsp_vec(),
                     {1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        end
        $display("timeout: id=%0d err=%0d timeout=%0d", bus.o_rsp_id, bus.o_rsp_err, bus.o_rsp_timeout);
        tick();
        bus.i_req0_VALID = 1;
        tick();                 // ISSUE
        bus.i_req0_VALID = 0;
        tick();                 // WAIT entry
        for (int i = 0; i < 14; i++) begin
            tick();
        end
        bus.i_alu_VALID = 1; bus.i_alu_Y = 4'h3; bus.i_alu_overflow = 1;
        asserts++;
        if ({bus.o_alu_READY, bus.o_rsp_VALID} !== 2'b10) begin
            fails++;
            $display("FAIL late_wait15: got %b expected 10", {bus.o_alu_READY, bus.o_rsp_VALID});
        end
        tick();
        bus.i_alu_VALID = 0;
        asserts++;
        if (rsp_vec() !== {1'b1, 1'b0, 4'h3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL late_resp: got %b expected %b", rsp_vec(),
                     {1'b1, 1'b0, 4'h3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        end
        $display("late result: id=%0d Y=%h timeout=%0d", bus.o_rsp_id, bus.o_rsp_Y, bus.o_rsp_timeout);
        tick();
        clear_inputs();
    endtask

    task automatic test_flags();
        do_reset();
        issue_min(1'b0, 2'b00, 4'h5, 4'h5, 4'h0, 1'b0, 1'b1);
        asserts++;
        if (rsp_vec() !== {1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL flags_zero: got %b expected %b", rsp_vec(),
                     {1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        end
        $display("flags: Y=%h neg=%0d pos=%0d ovf=%0d", bus.o_rsp_Y, bus.o_rsp_neg,
                 bus.o_rsp_pos, bus.o_rsp_overflow);
        tick();
        issue_min(1'b1, 2'b01, 4'hA, 4'hC, 4'h7, 1'b1, 1'b0);
        asserts++;
        if (rsp_vec() !== {1'b1, 1'b1, 4'h7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL flags_pos: got %b expected %b", rsp_vec(),
                     {1'b1, 1'b1, 4'h7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
        end
        $display("flags: Y=%h neg=%0d pos=%0d err=%0d", bus.o_rsp_Y, bus.o_rsp_neg,
                 bus.o_rsp_pos, bus.o_rsp_err);
        tick();
        issue_min(1'b0, 2'b10, 4'h0, 4'h0, 4'h8, 1'b0, 1'b0);
        asserts++;
        if (rsp_vec() !== {1'b1, 1'b0, 4'h8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL flags_neg: got %b expected %b", rsp_vec(),
                     {1'b1, 1'b0, 4'h8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        end
        $display("flags: Y=%h neg=%0d pos=%0d", bus.o_rsp_Y, bus.o_rsp_neg, bus.o_rsp_pos);
        tick();
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_contention();
        test_back_to_back_backpressure();
        test_timeout();
        test_flags();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end
endmodule
